// File: rtl/csr_file_pkg.sv
// Shared CSR constants: ALU op encoding, CSR address map, mstatus bit
// positions, the misa value and helpers that classify/mask CSR accesses.
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_OP_PASS  = 2'd0,
    CSR_OP_OR    = 2'd1,
    CSR_OP_CLEAR = 2'd2
  } csr_alu_op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_VSTART   = 12'h008;
  localparam logic [11:0] CSR_VL       = 12'hC20;
  localparam logic [11:0] CSR_VTYPE    = 12'hC21;
  localparam logic [11:0] CSR_VLENB    = 12'hC22;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // MXL = 1 (RV32), extension bits I (8) and V (21)
  localparam logic [31:0] MISA_VALUE  = 32'h4020_0100;
  localparam logic [31:0] VTYPE_RESET = 32'h8000_0000;

  // True for every address this register file decodes.
  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
      CSR_VSTART, CSR_VL, CSR_VTYPE, CSR_VLENB: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Value a write would read back as, after WARL masking of the target.
  function automatic logic [31:0] csr_write_mask(input logic [11:0] addr,
                                                 input logic [31:0] data);
    logic [31:0] v;
    v = data;
    case (addr)
      CSR_MSTATUS: begin
        v = '0;
        v[12:11] = 2'b11;
        v[MSTATUS_MIE]  = data[MSTATUS_MIE];
        v[MSTATUS_MPIE] = data[MSTATUS_MPIE];
      end
      CSR_MISA:  v = MISA_VALUE;
      CSR_MTVEC: v = data & ~32'h3;
      CSR_MEPC:  v = data & ~32'h3;
      default:   v = data;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with per-half software write ports.
// A write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_value
);

  logic [63:0] r_count;

  // Software writes take precedence; otherwise count up and wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_we_lo || i_we_hi) begin
      if (i_we_lo) r_count[31:0]  <= i_wdata;
      if (i_we_hi) r_count[63:32] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_value = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file: combinational read with WB bypass for EX,
// WB commit of ALU results, trap/mret state, 64-bit counters, vector CSRs.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int          VLEN        = 128,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] csr_raddr,
  input  logic        csr_access,
  input  logic        csr_write_intent,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        instr_retired,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        vset_we,
  input  logic [31:0] vset_vl,
  input  logic [31:0] vset_vtype,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  localparam logic [31:0] VLENB_VALUE = 32'(VLEN / 8);

  logic        r_status_mie;
  logic        r_status_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_vstart;
  logic [31:0] r_vl;
  logic [31:0] r_vtype;

  logic        w_wr_ok;
  logic        w_commit;
  logic [31:0] w_wdata_m;
  logic [31:0] w_mstatus;
  logic [31:0] w_rdata_raw;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic        w_raddr_impl;

  // Writes to unimplemented or read-only space never take effect; a trap
  // in the same cycle squashes whatever WB was committing.
  assign w_wr_ok   = csr_we & csr_implemented(csr_waddr) & (csr_waddr[11:10] != 2'b11);
  assign w_commit  = w_wr_ok & ~trap_valid;
  assign w_wdata_m = csr_write_mask(csr_waddr, csr_wdata);

  csr_counter64 u_mcycle (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (1'b1),
    .i_we_lo (w_commit & (csr_waddr == CSR_MCYCLE)),
    .i_we_hi (w_commit & (csr_waddr == CSR_MCYCLEH)),
    .i_wdata (csr_wdata),
    .o_value (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (instr_retired),
    .i_we_lo (w_commit & (csr_waddr == CSR_MINSTRET)),
    .i_we_hi (w_commit & (csr_waddr == CSR_MINSTRETH)),
    .i_wdata (csr_wdata),
    .o_value (w_minstret)
  );

  // mstatus interrupt-enable stack: trap pushes, mret pops, else software write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status_mie  <= 1'b0;
      r_status_mpie <= 1'b0;
    end else if (trap_valid) begin
      r_status_mpie <= r_status_mie;
      r_status_mie  <= 1'b0;
    end else if (mret) begin
      r_status_mie  <= r_status_mpie;
      r_status_mpie <= 1'b1;
    end else if (w_commit && (csr_waddr == CSR_MSTATUS)) begin
      r_status_mie  <= w_wdata_m[MSTATUS_MIE];
      r_status_mpie <= w_wdata_m[MSTATUS_MPIE];
    end
  end

  // Trap-state and scratch CSRs: trap capture beats any software write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trap_valid) begin
      r_mepc   <= trap_pc & ~32'h3;
      r_mcause <= trap_cause;
      r_mtval  <= trap_tval;
    end else if (w_commit) begin
      case (csr_waddr)
        CSR_MIE:      r_mie      <= w_wdata_m;
        CSR_MTVEC:    r_mtvec    <= w_wdata_m;
        CSR_MSCRATCH: r_mscratch <= w_wdata_m;
        CSR_MEPC:     r_mepc     <= w_wdata_m;
        CSR_MCAUSE:   r_mcause   <= w_wdata_m;
        CSR_MTVAL:    r_mtval    <= w_wdata_m;
        default: ;
      endcase
    end
  end

  // Vector state: vsetvl commits vl/vtype and restarts vstart, winning over
  // a software vstart write in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vstart <= '0;
      r_vl     <= '0;
      r_vtype  <= VTYPE_RESET;
    end else if (vset_we) begin
      r_vstart <= '0;
      r_vl     <= vset_vl;
      r_vtype  <= vset_vtype;
    end else if (w_commit && (csr_waddr == CSR_VSTART)) begin
      r_vstart <= w_wdata_m;
    end
  end

  always_comb begin
    w_mstatus = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[MSTATUS_MIE]  = r_status_mie;
    w_mstatus[MSTATUS_MPIE] = r_status_mpie;
  end

  // Architectural read mux; counters show their pre-increment value.
  always_comb begin
    w_rdata_raw = '0;
    case (csr_raddr)
      CSR_MSTATUS:                 w_rdata_raw = w_mstatus;
      CSR_MISA:                    w_rdata_raw = MISA_VALUE;
      CSR_MIE:                     w_rdata_raw = r_mie;
      CSR_MTVEC:                   w_rdata_raw = r_mtvec;
      CSR_MSCRATCH:                w_rdata_raw = r_mscratch;
      CSR_MEPC:                    w_rdata_raw = r_mepc;
      CSR_MCAUSE:                  w_rdata_raw = r_mcause;
      CSR_MTVAL:                   w_rdata_raw = r_mtval;
      CSR_MCYCLE, CSR_CYCLE:       w_rdata_raw = w_mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     w_rdata_raw = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_rdata_raw = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata_raw = w_minstret[63:32];
      CSR_VSTART:                  w_rdata_raw = r_vstart;
      CSR_VL:                      w_rdata_raw = r_vl;
      CSR_VTYPE:                   w_rdata_raw = r_vtype;
      CSR_VLENB:                   w_rdata_raw = VLENB_VALUE;
      default:                     w_rdata_raw = '0;
    endcase
  end

  // EX sees the WB value early when both stages touch the same CSR.
  always_comb begin
    csr_rdata = w_rdata_raw;
    if (w_wr_ok && (csr_waddr == csr_raddr)) begin
      csr_rdata = w_wdata_m;
    end
  end

  // Unimplemented addresses and writes into read-only space are illegal.
  always_comb begin
    w_raddr_impl = csr_implemented(csr_raddr);
    csr_illegal  = csr_access &
                   (~w_raddr_impl | (csr_write_intent & (csr_raddr[11:10] == 2'b11)));
  end

  assign mtvec_out  = r_mtvec;
  assign mepc_out   = r_mepc;
  assign mie_global = r_status_mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_csr_file;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0100;

  logic        clock;
  logic        reset;
  logic [11:0] csr_raddr;
  logic        csr_access;
  logic        csr_write_intent;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        instr_retired;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret;
  logic        vset_we;
  logic [31:0] vset_vl;
  logic [31:0] vset_vtype;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_global;

  typedef struct {
    string       name;
    logic        chkRd;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic        mie;
  } exp_t;

  exp_t        scoreboard[$];
  logic        chkValid;
  int          checks;
  int          errors;
  logic [31:0] expMepc;
  logic [31:0] expMtvec;
  logic        expMie;

  csr_file #(
    .VLEN        (128),
    .MTVEC_RESET (TB_MTVEC_RESET)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .csr_raddr        (csr_raddr),
    .csr_access       (csr_access),
    .csr_write_intent (csr_write_intent),
    .csr_rdata        (csr_rdata),
    .csr_illegal      (csr_illegal),
    .csr_we           (csr_we),
    .csr_waddr        (csr_waddr),
    .csr_wdata        (csr_wdata),
    .instr_retired    (instr_retired),
    .trap_valid       (trap_valid),
    .trap_pc          (trap_pc),
    .trap_cause       (trap_cause),
    .trap_tval        (trap_tval),
    .mret             (mret),
    .vset_we          (vset_we),
    .vset_vl          (vset_vl),
    .vset_vtype       (vset_vtype),
    .mtvec_out        (mtvec_out),
    .mepc_out         (mepc_out),
    .mie_global       (mie_global)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compareField(input string name, input string field,
                              input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.chkRd) compareField(e.name, "rdata", csr_rdata, e.rdata);
    compareField(e.name, "illegal", {31'b0, csr_illegal}, {31'b0, e.illegal});
    compareField(e.name, "mepc_out", mepc_out, e.mepc);
    compareField(e.name, "mtvec_out", mtvec_out, e.mtvec);
    compareField(e.name, "mie_global", {31'b0, mie_global}, {31'b0, e.mie});
  endtask

  // Monitor: compares the DUT against the oldest expectation mid-cycle.
  always @(negedge clock) begin
    if (chkValid) begin
      if (scoreboard.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard got empty queue expected an entry");
      end else begin
        checkOutput(scoreboard.pop_front());
      end
    end
  end

  task automatic clearPulses();
    csr_access       = 1'b1;
    csr_write_intent = 1'b0;
    csr_we           = 1'b0;
    csr_waddr        = 12'h000;
    csr_wdata        = 32'h0;
    instr_retired    = 1'b0;
    trap_valid       = 1'b0;
    trap_pc          = 32'h0;
    trap_cause       = 32'h0;
    trap_tval        = 32'h0;
    mret             = 1'b0;
    vset_we          = 1'b0;
    vset_vl          = 32'h0;
    vset_vtype       = 32'h0;
  endtask

  task automatic setWrite(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_waddr = addr;
    csr_wdata = data;
  endtask

  // One cycle: queue the expectation for the current inputs, advance a clock.
  task automatic applyStimulus(input string name, input logic [11:0] raddr,
                               input logic chkRd, input logic [31:0] expRd,
                               input logic expIll);
    exp_t e;
    csr_raddr = raddr;
    e.name    = name;
    e.chkRd   = chkRd;
    e.rdata   = expRd;
    e.illegal = expIll;
    e.mepc    = expMepc;
    e.mtvec   = expMtvec;
    e.mie     = expMie;
    scoreboard.push_back(e);
    chkValid = 1'b1;
    @(posedge clock);
    #1;
    chkValid = 1'b0;
    clearPulses();
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    chkValid = 1'b0;
    reset    = 1'b1;
    csr_raddr = 12'h000;
    clearPulses();
    expMepc  = 32'h0;
    expMtvec = TB_MTVEC_RESET;
    expMie   = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    applyStimulus("rst_mtvec", 12'h305, 1, TB_MTVEC_RESET, 0);
    reset = 1'b0;
    applyStimulus("rst_vtype",   12'hC21, 1, 32'h8000_0000, 0);
    applyStimulus("rst_mstatus", 12'h300, 1, 32'h0000_1800, 0);
    applyStimulus("misa",        12'h301, 1, 32'h4020_0100, 0);
    applyStimulus("vlenb",       12'hC22, 1, 32'd16, 0);

    setWrite(12'h340, 32'hDEAD_BEEF);
    applyStimulus("mscratch_bypass", 12'h340, 1, 32'hDEAD_BEEF, 0);
    applyStimulus("mscratch_read",   12'h340, 1, 32'hDEAD_BEEF, 0);

    setWrite(12'h305, 32'h0000_0203);
    applyStimulus("mtvec_bypass", 12'h305, 1, 32'h0000_0200, 0);
    expMtvec = 32'h0000_0200;
    applyStimulus("mtvec_read", 12'h305, 1, 32'h0000_0200, 0);

    setWrite(12'hB80, 32'h0);
    applyStimulus("mcycleh_wr", 12'hB80, 1, 32'h0, 0);
    setWrite(12'hB00, 32'hFFFF_FFFE);
    applyStimulus("mcycle_wr", 12'hB00, 1, 32'hFFFF_FFFE, 0);
    applyStimulus("mcycle_t0", 12'hB00, 1, 32'hFFFF_FFFE, 0);
    applyStimulus("mcycle_t1", 12'hB00, 1, 32'hFFFF_FFFF, 0);
    applyStimulus("mcycleh_carry", 12'hB80, 1, 32'h1, 0);
    applyStimulus("mcycle_after",  12'hB00, 1, 32'h1, 0);
    applyStimulus("cycleh_alias",  12'hC80, 1, 32'h1, 0);

    csr_write_intent = 1'b1;
    applyStimulus("ill_ro_write", 12'hC00, 0, 32'h0, 1);
    applyStimulus("ill_ro_read",  12'hC00, 0, 32'h0, 0);
    applyStimulus("ill_unimpl",   12'h7FF, 1, 32'h0, 1);
    csr_access = 1'b0;
    applyStimulus("ill_noaccess", 12'h7FF, 1, 32'h0, 0);
    csr_write_intent = 1'b1;
    applyStimulus("legal_rw", 12'h340, 1, 32'hDEAD_BEEF, 0);

    for (int i = 0; i < 3; i++) begin
      instr_retired = 1'b1;
      applyStimulus("minstret_inc", 12'hB02, 1, 32'(i), 0);
    end
    applyStimulus("instret_alias", 12'hC02, 1, 32'd3, 0);
    applyStimulus("minstreth",     12'hB82, 1, 32'd0, 0);

    setWrite(12'hC20, 32'h0000_1234);
    applyStimulus("ro_write_nobypass", 12'hC20, 1, 32'h0, 0);
    applyStimulus("ro_write_ignored",  12'hC20, 1, 32'h0, 0);
    setWrite(12'h301, 32'h0);
    applyStimulus("misa_write", 12'h301, 1, 32'h4020_0100, 0);

    setWrite(12'h300, 32'h0000_0008);
    applyStimulus("mstatus_wr", 12'h300, 1, 32'h0000_1808, 0);
    expMie = 1'b1;
    applyStimulus("mstatus_rd", 12'h300, 1, 32'h0000_1808, 0);

    trap_valid = 1'b1;
    trap_pc    = 32'h0000_1006;
    trap_cause = 32'd11;
    trap_tval  = 32'h0000_0ABC;
    setWrite(12'h340, 32'h1234_5678);
    applyStimulus("trap_cycle", 12'h341, 1, 32'h0, 0);
    expMepc = 32'h0000_1004;
    expMie  = 1'b0;
    applyStimulus("trap_mepc",    12'h341, 1, 32'h0000_1004, 0);
    applyStimulus("trap_mcause",  12'h342, 1, 32'd11, 0);
    applyStimulus("trap_mtval",   12'h343, 1, 32'h0000_0ABC, 0);
    applyStimulus("trap_dropwr",  12'h340, 1, 32'hDEAD_BEEF, 0);
    applyStimulus("trap_mstatus", 12'h300, 1, 32'h0000_1880, 0);

    mret = 1'b1;
    setWrite(12'h340, 32'h0000_5555);
    applyStimulus("mret_cycle", 12'h341, 1, 32'h0000_1004, 0);
    expMie = 1'b1;
    applyStimulus("mret_mstatus", 12'h300, 1, 32'h0000_1888, 0);
    applyStimulus("mret_otherwr", 12'h340, 1, 32'h0000_5555, 0);
    mret = 1'b1;
    setWrite(12'h300, 32'h0);
    applyStimulus("mret_dropmst", 12'h340, 1, 32'h0000_5555, 0);
    applyStimulus("mret_mst_kept", 12'h300, 1, 32'h0000_1888, 0);

    setWrite(12'h008, 32'd3);
    applyStimulus("vstart_bypass", 12'h008, 1, 32'd3, 0);
    applyStimulus("vstart_read",   12'h008, 1, 32'd3, 0);
    vset_we    = 1'b1;
    vset_vl    = 32'd4;
    vset_vtype = 32'h0000_0008;
    applyStimulus("vset_cycle", 12'hC20, 1, 32'd0, 0);
    applyStimulus("vset_vl",    12'hC20, 1, 32'd4, 0);
    applyStimulus("vset_vtype", 12'hC21, 1, 32'h0000_0008, 0);
    applyStimulus("vset_vstart", 12'h008, 1, 32'd0, 0);
    applyStimulus("vset_vlenb", 12'hC22, 1, 32'd16, 0);
    vset_we    = 1'b1;
    vset_vl    = 32'd7;
    vset_vtype = 32'h0000_0010;
    setWrite(12'h008, 32'd9);
    applyStimulus("vset_vs_race", 12'hC21, 1, 32'h0000_0008, 0);
    applyStimulus("vset_vs_wins", 12'h008, 1, 32'd0, 0);
    applyStimulus("vset_vl2",     12'hC20, 1, 32'd7, 0);

    reset    = 1'b1;
    expMepc  = 32'h0;
    expMtvec = TB_MTVEC_RESET;
    expMie   = 1'b0;
    applyStimulus("midrst_mscratch", 12'h340, 1, 32'h0, 0);
    reset = 1'b0;
    applyStimulus("midrst_mstatus", 12'h300, 1, 32'h0000_1800, 0);
    applyStimulus("midrst_vtype",   12'hC21, 1, 32'h8000_0000, 0);

    @(negedge clock);
    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file: the write-back end of the CSR datapath whose ALU op (PASS/OR/CLEAR) and immediate select come from the EX-stage ALU control.
- Supplies old CSR value to EX (rd result and ALU operand A).
- Commits ALU-computed new value in WB.
- Also holds 64-bit cycle/instret counters, trap entry/return state and vector CSRs (vstart, vl, vtype, vlenb).

Parameters:
- VLEN, 128, vector register length in bits; vlenb reads VLEN/8.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- csr_raddr  input  12  CSR address of the EX-stage instruction.
- csr_access  input  1  EX instruction is a CSR op.
- csr_write_intent  input  1  EX op will write (CSRRW/I always; S/C when rs1/uimm != 0).
- csr_rdata  output  32  current value at csr_raddr (combinational).
- csr_illegal  output  1  illegal CSR access detected in EX.
- csr_we  input  1  WB commit of CSR write.
- csr_waddr  input  12  WB CSR address.
- csr_wdata  input  32  new value from the ALU result.
- instr_retired  input  1  one instruction retires this cycle.
- trap_valid  input  1  take trap this cycle.
- trap_pc  input  32  PC to save.
- trap_cause  input  32  cause code.
- trap_tval  input  32  trap value.
- mret  input  1  MRET retires this cycle.
- vset_we  input  1  vsetvl/vsetvli result commits.
- vset_vl  input  32  new vl.
- vset_vtype  input  32  new vtype.
- mtvec_out  output  32  trap vector base to fetch.
- mepc_out  output  32  return PC to fetch.
- mie_global  output  1  mstatus.MIE.

Behaviour:
Reset (asynchronous, immediate on reset high; clock and reset are the only clock/reset):
- All registers 0, except mtvec = MTVEC_RESET and vtype = 32'h8000_0000 (vill = 1).
- Outputs at reset: mtvec_out = MTVEC_RESET, mepc_out = 0, mie_global = 0.
- csr_rdata and csr_illegal are combinational and follow their inputs.
- Reset mid-operation discards any in-flight write; counters restart at 0.

Address map:
- mstatus 0x300: only MIE[3] and MPIE[7] are storable; MPP[12:11] reads 2'b11; other bits read 0.
- misa 0x301: reads RV32I|V; writes ignored.
- mie 0x304.
- mtvec 0x305: bits[1:0] forced 0.
- mscratch 0x340.
- mepc 0x341: bits[1:0] forced 0.
- mcause 0x342.
- mtval 0x343.
- mcycle / mcycleh: 0xB00 / 0xB80.
- minstret / minstreth: 0xB02 / 0xB82.
- cycle, cycleh, instret, instreth: 0xC00, 0xC80, 0xC02, 0xC82 (read-only aliases).
- vstart 0x008 (RW).
- vl 0xC20, vtype 0xC21, vlenb 0xC22: read-only.

Read path:
- Zero-latency read.
- WB-to-EX bypass: if csr_we and csr_waddr == csr_raddr, csr_rdata = the masked csr_wdata.
- Counter reads return pre-increment current value; no bypass of the increment.

Illegal access:
- csr_illegal = csr_access & (address unimplemented | (csr_write_intent & csr_raddr[11:10] == 2'b11)).
- Illegal writes never reach WB; csr_we with an unimplemented or read-only address is ignored.

Counters:
- mcycle increments every cycle.
- minstret increments when instr_retired.
- 64-bit wrap from all-ones to 0.
- A software write to either half in the same cycle wins: that half takes csr_wdata, the other half holds, and there is no increment this cycle.

Priority per cycle, highest first: trap_valid, mret, csr_we.
- Trap: mepc = trap_pc & ~3, mcause = trap_cause, mtval = trap_tval, MPIE = MIE, MIE = 0. Any csr_we the same cycle is dropped.
- mret: MIE = MPIE, MPIE = 1. A concurrent csr_we to mstatus is dropped; csr_we to other addresses still commits.
- vset_we: vl and vtype update, vstart cleared. Independent of the above, except a simultaneous csr_we to vstart loses.

Decomposition:
- Shared constants package (alongside the existing ALU/funct3 constants):
  - CSR address defines: CSR_MSTATUS … CSR_VLENB.
  - mstatus bit positions: MSTATUS_MIE = 3, MSTATUS_MPIE = 7.
  - MISA value.
- One natural sub-module: csr_counter64, a 64-bit counter with increment enable and two half-word write ports, instantiated for mcycle and minstret.

Test Plan:
- Reset, then read 0x305 and 0xC21 -> MTVEC_RESET and 32'h8000_0000; read 0x300 -> 32'h0000_1800.
- csr_we to 0x340 with 32'hDEAD_BEEF while csr_raddr = 0x340 -> csr_rdata = DEAD_BEEF the same cycle (bypass) and on later cycles.
- Write mcycle = 32'hFFFF_FFFE, mcycleh = 0 -> after 3 cycles, mcycleh reads 1 and mcycle reads 1 (carry into high half).
- csr_access = 1, csr_write_intent = 1, csr_raddr = 0xC00 -> csr_illegal = 1. Same with csr_write_intent = 0 -> csr_illegal = 0. Address 0x7FF -> csr_illegal = 1.
- MIE = 1, trap_valid with trap_pc = 32'h0000_1006, cause = 11, plus simultaneous csr_we to mscratch -> mepc = 0x1004, mcause = 11, MIE = 0, MPIE = 1, mscratch unchanged. Then mret -> MIE = 1, MPIE = 1.
- vset_we with vl = 4, vtype = 0x08 while vstart = 3 -> vl reads 4, vtype reads 8, vstart reads 0; vlenb reads 16 (VLEN = 128).
